parallel_fir_convolver: RTL and testbench
=========================================

Name: parallel_fir_convolver

Overview:
- Next-generation direct-form FIR convolution engine for the live audio path.
- On each audio sample strobe it stores the sample in an internal circular history and computes y[n] = sum over k of h[k]·x[n−k], for k = 0..IMPULSE_LENGTH−1.
- Uses LANES parallel MAC lanes. Impulse coefficients are fetched from an external impulse memory through a fixed-latency read port.
- Sits between the audio input framing logic and the output mixer. Adds parametrised width, depth and lane count, history clearing, overrun detection and a narrowed sample output.

Parameters:
- SAMPLE_WIDTH, 16, signed audio sample width.
- COEF_WIDTH, 16, signed impulse coefficient width.
- ACC_WIDTH, 48, accumulator and result width.
- IMPULSE_LENGTH, 24000, taps; must be a multiple of LANES.
- LANES, 8, parallel MAC lanes; power of two, 1..16.
- IR_LATENCY, 2, cycles from ir_addr to valid ir_vals.
- OUT_SHIFT, 16, right-shift applied to form sample_out.

Ports:
- audio_clk  in  1  sole clock.
- rst_in  in  1  synchronous, active-high reset.
- impulse_ready  in  1  level; impulse memory fully loaded.
- audio_trigger  in  1  one-cycle strobe; audio_in valid.
- audio_in  in  SAMPLE_WIDTH  signed sample.
- ir_addr  out  clog2(IMPULSE_LENGTH/LANES)  coefficient word index j.
- ir_vals  in  LANES×COEF_WIDTH  h[j·LANES+l] on lane l.
- convolution_result  out  ACC_WIDTH  signed y[n].
- sample_out  out  SAMPLE_WIDTH  narrowed y[n].
- result_valid  out  1  one-cycle pulse.
- busy  out  1  high outside IDLE.
- dropped_sample  out  1  one-cycle pulse on rejected trigger.

Behaviour:
- Constants: TAPS_PER_LANE = IMPULSE_LENGTH/LANES; LATENCY = TAPS_PER_LANE + IR_LATENCY + LANES + 2.
- Reset (synchronous; also aborts any operation in progress):
  - convolution_result = 0, sample_out = 0, result_valid = 0, dropped_sample = 0, ir_addr = 0.
  - Write pointer = 0; all accumulators = 0.
  - State goes to CLEARING; busy = 1.
- FSM: CLEARING → WAIT_IMPULSE → IDLE → WRITE → MAC → DRAIN → REDUCE → IDLE.
  - CLEARING: writes zero to all IMPULSE_LENGTH history entries, all lanes in parallel, over TAPS_PER_LANE cycles. Then goes to WAIT_IMPULSE.
  - WAIT_IMPULSE: goes to IDLE once impulse_ready = 1. Triggers are ignored here, with no drop flag.
  - IDLE: busy = 0. On audio_trigger, captures audio_in and goes to WRITE.
  - WRITE: one cycle. Stores the sample as x[n] at the write pointer.
  - MAC: j runs 0..TAPS_PER_LANE−1, one per cycle; ir_addr = j. Lane l accumulates h[j·LANES+l]·x[n−j·LANES−l].
  - DRAIN: IR_LATENCY cycles to flush the pipeline.
  - REDUCE: sums the LANES accumulators sequentially, one per cycle, plus one register stage. Then result_valid pulses with convolution_result and sample_out, the write pointer advances modulo IMPULSE_LENGTH, and the state returns to IDLE.
- Latency: result_valid is asserted exactly LATENCY cycles after the trigger cycle.
- Outputs hold until the next result.
- History indexing:
  - x[n−k] is taken modulo IMPULSE_LENGTH, wrapping correctly when the pointer is near 0.
  - Storage is banked: sample index i is stored in bank i mod LANES at row i/LANES. Lane data is rotated by n mod LANES to align taps.
- Arithmetic:
  - Each product is full-precision SAMPLE_WIDTH + COEF_WIDTH, sign-extended to ACC_WIDTH.
  - Accumulation wraps two's-complement; no saturation inside the accumulators.
- Overrun:
  - audio_trigger while busy in WRITE..REDUCE pulses dropped_sample in the next cycle.
  - The sample is discarded, the history is untouched and the current computation is unaffected.
  - A trigger in the same cycle as result_valid is also dropped.
- Mid-run loss of impulse: impulse_ready deasserting mid-computation does not abort it. The FSM re-checks impulse_ready only in IDLE and goes to WAIT_IMPULSE if it is low.

Optional Feature:
- Macro: CONV_OUTPUT_SATURATE_EN.
- Defined: sample_out = convolution_result >>> OUT_SHIFT, clamped to [−2^(SAMPLE_WIDTH−1), 2^(SAMPLE_WIDTH−1)−1].
- Undefined: sample_out = low SAMPLE_WIDTH bits of convolution_result >>> OUT_SHIFT, wrapping.
- convolution_result is identical in both cases.

Decomposition:
- Package conv_pkg holds:
  - the state enum typedef;
  - helper functions for TAPS_PER_LANE and LATENCY;
  - the saturation function.
- Sub-module fir_mac_lane, one instance per lane, contains:
  - the lane's history bank (a dual-port BRAM wrapper instance);
  - the multiplier;
  - the accumulator with clear and enable.

Test Plan (LANES=4, IMPULSE_LENGTH=16, IR_LATENCY=2, OUT_SHIFT=0):
- Reset, then impulse_ready=1 → busy stays high for 4 clearing cycles; the first result with h=δ[0] and x=100 is 100; no stale data in the history.
- h=δ[5]; feed x=1,2,3,...,20 → outputs are 0,0,0,0,0,1,2,...,15. Check result_valid occurs exactly 12 cycles after each trigger and that the output wraps correctly past pointer 15.
- h[k]=1 for all k; feed 20 samples of 1000 → outputs ramp 1000, 2000, ..., 16000, then hold at 16000.
- Trigger 3 cycles after a prior trigger → dropped_sample pulses once; the first result is unchanged; the next accepted sample is treated as x[n+1].
- Assert rst_in mid-MAC → no result_valid pulse occurs; the FSM re-clears; the next result with h=δ[0] and x=−7 is −7.
- CONV_OUTPUT_SATURATE_EN defined, h=δ[0]·32767, x=32767 → sample_out = 32767. Undefined → sample_out = the wrapped value 1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the parallel FIR convolver: FSM state encoding,
// derived-size helpers and the output saturation function.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_CLEARING,
    ST_WAIT_IMPULSE,
    ST_IDLE,
    ST_WRITE,
    ST_MAC,
    ST_DRAIN,
    ST_REDUCE
  } conv_state_e;

  function automatic int taps_per_lane(input int impulse_length, input int lanes);
    return impulse_length / lanes;
  endfunction

  function automatic int conv_latency(input int impulse_length, input int lanes,
                                      input int ir_latency);
    return taps_per_lane(impulse_length, lanes) + ir_latency + lanes + 2;
  endfunction

  function automatic int ir_addr_width(input int impulse_length, input int lanes);
    int tpl;
    tpl = taps_per_lane(impulse_length, lanes);
    return (tpl > 1) ? $clog2(tpl) : 1;
  endfunction

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One MAC lane: a banked slice of the sample history (registered-read BRAM)
// feeding a full-precision multiplier and a wrapping accumulator.
module conv_hist_bram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 3000,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

module fir_mac_lane
  import conv_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int ACC_WIDTH    = 48,
  parameter int DEPTH        = 3000,
  parameter int ROW_W        = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [ROW_W-1:0]        wr_row_i,
  input  logic [SAMPLE_WIDTH-1:0] wr_data_i,
  input  logic                    rd_en_i,
  input  logic [ROW_W-1:0]        rd_row_i,
  input  logic [COEF_WIDTH-1:0]   coef_i,
  input  logic                    acc_clr_i,
  output logic [ACC_WIDTH-1:0]    acc_o
);

  localparam int PW = SAMPLE_WIDTH + COEF_WIDTH;

  logic [SAMPLE_WIDTH-1:0]     hist_rd;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        vld_q;

  conv_hist_bram #(
    .DATA_W (SAMPLE_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ROW_W)
  ) u_bank (
    .clk_i   (clk_i),
    .we_i    (wr_en_i),
    .waddr_i (wr_row_i),
    .wdata_i (wr_data_i),
    .re_i    (rd_en_i),
    .raddr_i (rd_row_i),
    .rdata_o (hist_rd)
  );

  // Read data lands one cycle after the request, aligned with its coefficient.
  always_ff @(posedge clk_i) begin
    if (rst_i) vld_q <= 1'b0;
    else       vld_q <= rd_en_i;
  end

  assign prod     = $signed(hist_rd) * $signed(coef_i);
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk_i) begin
    if (rst_i || acc_clr_i) acc_q <= '0;
    else if (vld_q)         acc_q <= acc_q + prod_ext;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/parallel_fir_convolver.sv
// Direct-form FIR convolver with LANES parallel MAC lanes over a banked history.
// Optional macro CONV_OUTPUT_SATURATE_EN clamps sample_out instead of wrapping it.
module parallel_fir_convolver
  import conv_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int COEF_WIDTH     = 16,
  parameter int ACC_WIDTH      = 48,
  parameter int IMPULSE_LENGTH = 24000,
  parameter int LANES          = 8,
  parameter int IR_LATENCY     = 2,
  parameter int OUT_SHIFT      = 16
) (
  input  logic                                            audio_clk,
  input  logic                                            rst_in,
  input  logic                                            impulse_ready,
  input  logic                                            audio_trigger,
  input  logic [SAMPLE_WIDTH-1:0]                         audio_in,
  output logic [ir_addr_width(IMPULSE_LENGTH, LANES)-1:0] ir_addr,
  input  logic [LANES*COEF_WIDTH-1:0]                     ir_vals,
  output logic [ACC_WIDTH-1:0]                            convolution_result,
  output logic [SAMPLE_WIDTH-1:0]                         sample_out,
  output logic                                            result_valid,
  output logic                                            busy,
  output logic                                            dropped_sample
);

  localparam int TPL   = taps_per_lane(IMPULSE_LENGTH, LANES);
  localparam int ROW_W = ir_addr_width(IMPULSE_LENGTH, LANES);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = $clog2(TPL + IR_LATENCY + LANES + 1);

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(TPL - 1);
  localparam logic [LW-1:0]    BANK_LAST = LW'(LANES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(TPL - 1);
  localparam logic [CNT_W-1:0] DRN_LAST  = CNT_W'(IR_LATENCY - 1);
  localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(LANES - 1);

  conv_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ROW_W-1:0]            j_q, j_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [ROW_W-1:0]            ptr_row_q, ptr_row_d;
  logic [LW-1:0]               ptr_bank_q, ptr_bank_d;
  logic [SAMPLE_WIDTH-1:0]     sample_q, sample_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d, sum_next;
  logic [ACC_WIDTH-1:0]        result_q, result_d;
  logic [SAMPLE_WIDTH-1:0]     sample_out_q, sample_out_d, narrowed;
  logic                        valid_q, valid_d;
  logic                        drop_q, drop_d;
  logic                        clr_we, wr_we, acc_clr, mac_issue;
  logic                        rd_vld;
  logic [ROW_W-1:0]            rd_row;
  logic [ACC_WIDTH-1:0]        acc_w [LANES];
  logic signed [ACC_WIDTH-1:0] acc_sel;

  assign acc_sel  = $signed(acc_w[cnt_q[LW-1:0]]);
  assign sum_next = sum_q + acc_sel;

  always_comb begin
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [63:0]          wide;
    shifted = sum_next >>> OUT_SHIFT;
    wide    = {{(64-ACC_WIDTH){shifted[ACC_WIDTH-1]}}, shifted};
`ifdef CONV_OUTPUT_SATURATE_EN
    wide    = sat_to_width(wide, SAMPLE_WIDTH);
`endif
    narrowed = wide[SAMPLE_WIDTH-1:0];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    j_d          = j_q;
    row_d        = row_q;
    ptr_row_d    = ptr_row_q;
    ptr_bank_d   = ptr_bank_q;
    sample_d     = sample_q;
    sum_d        = sum_q;
    result_d     = result_q;
    sample_out_d = sample_out_q;
    valid_d      = 1'b0;
    drop_d       = 1'b0;
    clr_we       = 1'b0;
    wr_we        = 1'b0;
    acc_clr      = 1'b0;
    mac_issue    = 1'b0;

    // A trigger is rejected whenever a computation owns the history, including
    // the cycle its result is presented.
    if (audio_trigger && (state_q inside {ST_WRITE, ST_MAC, ST_DRAIN, ST_REDUCE} ||
                          (state_q == ST_IDLE && valid_q)))
      drop_d = 1'b1;

    case (state_q)
      ST_CLEARING: begin
        clr_we = 1'b1;
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_IMPULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_IMPULSE: begin
        if (impulse_ready) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!impulse_ready) begin
          state_d = ST_WAIT_IMPULSE;
        end else if (audio_trigger && !valid_q) begin
          sample_d = audio_in;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_we   = 1'b1;
        acc_clr = 1'b1;
        j_d     = '0;
        row_d   = ptr_row_q;
        sum_d   = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        mac_issue = 1'b1;
        row_d     = (row_q == '0) ? ROW_LAST : row_q - 1'b1;
        if (j_q == ROW_LAST) begin
          j_d     = '0;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRN_LAST) begin
          cnt_d   = '0;
          state_d = ST_REDUCE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REDUCE: begin
        sum_d = sum_next;
        if (cnt_q == RED_LAST) begin
          cnt_d        = '0;
          result_d     = sum_next;
          sample_out_d = narrowed;
          valid_d      = 1'b1;
          state_d      = ST_IDLE;
          if (ptr_bank_q == BANK_LAST) begin
            ptr_bank_d = '0;
            ptr_row_d  = (ptr_row_q == ROW_LAST) ? '0 : ptr_row_q + 1'b1;
          end else begin
            ptr_bank_d = ptr_bank_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_CLEARING;
    endcase
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_q      <= ST_CLEARING;
      cnt_q        <= '0;
      j_q          <= '0;
      ptr_row_q    <= '0;
      ptr_bank_q   <= '0;
      result_q     <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      j_q          <= j_d;
      ptr_row_q    <= ptr_row_d;
      ptr_bank_q   <= ptr_bank_d;
      result_q     <= result_d;
      sample_out_q <= sample_out_d;
      valid_q      <= valid_d;
      drop_q       <= drop_d;
    end
  end

  always_ff @(posedge audio_clk) begin
    sample_q <= sample_d;
    row_q    <= row_d;
    sum_q    <= sum_d;
  end

  // History reads are held back IR_LATENCY-1 cycles so the registered BRAM
  // output meets the coefficient word fetched for the same j.
  if (IR_LATENCY == 1) begin : g_nodly
    assign rd_vld = mac_issue;
    assign rd_row = row_q;
  end else begin : g_dly
    logic [IR_LATENCY-2:0] vld_pipe_q;
    logic [ROW_W-1:0]      row_pipe_q [IR_LATENCY-1];

    always_ff @(posedge audio_clk) begin
      if (rst_in) begin
        vld_pipe_q <= '0;
      end else begin
        vld_pipe_q[0] <= mac_issue;
        for (int i = 1; i < IR_LATENCY - 1; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end

    always_ff @(posedge audio_clk) begin
      row_pipe_q[0] <= row_q;
      for (int i = 1; i < IR_LATENCY - 1; i++) row_pipe_q[i] <= row_pipe_q[i-1];
    end

    assign rd_vld = vld_pipe_q[IR_LATENCY-2];
    assign rd_row = row_pipe_q[IR_LATENCY-2];
  end

  // Bank b holds samples with index mod LANES == b; for the current n it serves
  // tap lane (n - b) mod LANES, one row lower when b lies above n's bank.
  for (genvar b = 0; b < LANES; b++) begin : g_lane
    logic             we;
    logic [ROW_W-1:0] raddr;
    logic [LW-1:0]    rot;
    logic [COEF_WIDTH-1:0] coef;

    assign we    = clr_we | (wr_we & (ptr_bank_q == LW'(b)));
    assign raddr = (ptr_bank_q < LW'(b)) ? ((rd_row == '0) ? ROW_LAST : rd_row - 1'b1)
                                         : rd_row;
    assign rot   = ptr_bank_q - LW'(b);
    assign coef  = ir_vals[int'(rot)*COEF_WIDTH +: COEF_WIDTH];

    fir_mac_lane #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .COEF_WIDTH   (COEF_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH),
      .DEPTH        (TPL),
      .ROW_W        (ROW_W)
    ) u_lane (
      .clk_i     (audio_clk),
      .rst_i     (rst_in),
      .wr_en_i   (we),
      .wr_row_i  (clr_we ? cnt_q[ROW_W-1:0] : ptr_row_q),
      .wr_data_i (clr_we ? '0 : sample_q),
      .rd_en_i   (rd_vld),
      .rd_row_i  (raddr),
      .coef_i    (coef),
      .acc_clr_i (acc_clr),
      .acc_o     (acc_w[b])
    );
  end

  assign ir_addr            = j_q;
  assign convolution_result = result_q;
  assign sample_out         = sample_out_q;
  assign result_valid       = valid_q;
  assign dropped_sample     = drop_q;
  assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parallel_fir_convolver.sv
// Bench for parallel_fir_convolver at LANES=4, IMPULSE_LENGTH=16, IR_LATENCY=2, OUT_SHIFT=0.
module tb_parallel_fir_convolver;

  localparam int SW  = 16;
  localparam int CW  = 16;
  localparam int AW  = 48;
  localparam int IL  = 16;
  localparam int LN  = 4;
  localparam int IRL = 2;
  localparam int OSH = 0;
  localparam int LAT = IL / LN + IRL + LN + 2;

  logic              clk = 1'b0;
  logic              rst_in = 1'b0;
  logic              impulse_ready = 1'b0;
  logic              audio_trigger = 1'b0;
  logic [SW-1:0]     audio_in = '0;
  logic [1:0]        ir_addr;
  logic [LN*CW-1:0]  ir_vals;
  logic [AW-1:0]     convolution_result;
  logic [SW-1:0]     sample_out;
  logic              result_valid, busy, dropped_sample;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic signed [CW-1:0] h [IL];
  longint               hist [$];
  logic [1:0]           a1, a2;

  always #5 clk = ~clk;

  parallel_fir_convolver #(
    .SAMPLE_WIDTH (SW), .COEF_WIDTH (CW), .ACC_WIDTH (AW), .IMPULSE_LENGTH (IL),
    .LANES (LN), .IR_LATENCY (IRL), .OUT_SHIFT (OSH)
  ) dut (
    .audio_clk (clk), .rst_in (rst_in), .impulse_ready (impulse_ready),
    .audio_trigger (audio_trigger), .audio_in (audio_in), .ir_addr (ir_addr),
    .ir_vals (ir_vals), .convolution_result (convolution_result),
    .sample_out (sample_out), .result_valid (result_valid), .busy (busy),
    .dropped_sample (dropped_sample)
  );

  // Impulse memory with a two-cycle read latency.
  always @(posedge clk) begin
    a1 <= ir_addr;
    a2 <= a1;
  end
  always_comb begin
    ir_vals = '0;
    for (int l = 0; l < LN; l++) ir_vals[l*CW +: CW] = h[int'(a2)*LN + l];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_y();
    longint acc = 0;
    for (int k = 0; k < IL; k++)
      if (k < hist.size()) acc += longint'(h[k]) * hist[hist.size()-1-k];
    return acc;
  endfunction

  function automatic logic [SW-1:0] ref_sample(input longint y);
    longint s;
    s = y >>> OSH;
`ifdef CONV_OUTPUT_SATURATE_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[SW-1:0];
  endfunction

  task automatic set_delta(input int k, input int v);
    for (int i = 0; i < IL; i++) h[i] = '0;
    h[k] = CW'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    hist.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_idle", busy, 0);
  endtask

  task automatic wait_result(input int start, output int lat);
    lat = start;
    while (!result_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag);
    longint     y;
    logic [AW-1:0] ey;
    y  = ref_y();
    ey = y[AW-1:0];
    check({tag, "_result"}, 64'(convolution_result), 64'(ey));
    check({tag, "_sample_out"}, 64'(sample_out), 64'(ref_sample(y)));
  endtask

  task automatic send(input int x, input string tag);
    int lat;
    @(negedge clk);
    audio_trigger = 1'b1;
    audio_in      = SW'(x);
    @(negedge clk);
    audio_trigger = 1'b0;
    hist.push_back(longint'(x));
    wait_result(1, lat);
    check({tag, "_latency"}, lat, LAT);
    check_result(tag);
    @(negedge clk);
    check({tag, "_valid_pulse"}, result_valid, 0);
  endtask

  initial begin
    int lat;
    int n;
    bit seen;
    logic [15:0] r;

    for (int i = 0; i < IL; i++) h[i] = '0;

    // Reset values and clearing duration
    impulse_ready = 1'b1;
    do_reset();
    check("rst_result", 64'(convolution_result), 0);
    check("rst_sample_out", 64'(sample_out), 0);
    check("rst_valid", result_valid, 0);
    check("rst_dropped", dropped_sample, 0);
    check("rst_ir_addr", 64'(ir_addr), 0);
    check("rst_busy", busy, 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("clear_busy_cycles", n, 5);

    // Unit impulse, first sample
    set_delta(0, 1);
    send(100, "delta0_first");

    // Delayed impulse across a pointer wrap
    set_delta(5, 1);
    do_reset();
    wait_idle();
    for (int i = 1; i <= 20; i++) send(i, "delta5");

    // All-ones impulse: ramp then hold
    for (int i = 0; i < IL; i++) h[i] = 16'sd1;
    do_reset();
    wait_idle();
    for (int i = 0; i < 20; i++) send(1000, "ones_ramp");

    // Random impulse and samples, continuing the history
    for (int i = 0; i < IL; i++) h[i] = CW'($urandom);
    for (int i = 0; i < 24; i++) begin
      r = 16'($urandom);
      send(int'($signed(r)), "random");
    end

    // Overrun: trigger three cycles after an accepted one
    set_delta(1, 3);
    @(negedge clk);
    audio_trigger = 1'b1;
    audio_in      = SW'(250);
    @(negedge clk);
    audio_trigger = 1'b0;
    hist.push_back(250);
    repeat (2) @(negedge clk);
    audio_trigger = 1'b1;
    audio_in      = SW'(-999);
    @(negedge clk);
    audio_trigger = 1'b0;
    check("overrun_drop_pulse", dropped_sample, 1);
    @(negedge clk);
    check("overrun_drop_single", dropped_sample, 0);
    wait_result(5, lat);
    check("overrun_latency", lat, LAT);
    check_result("overrun");
    // Trigger coincident with result_valid is also rejected
    audio_trigger = 1'b1;
    audio_in      = SW'(777);
    @(negedge clk);
    audio_trigger = 1'b0;
    check("coincident_drop", dropped_sample, 1);
    check("coincident_no_start", busy, 0);
    send(-40, "after_overrun");

    // Reset in the middle of MAC aborts and re-clears
    @(negedge clk);
    audio_trigger = 1'b1;
    audio_in      = SW'(55);
    @(negedge clk);
    audio_trigger = 1'b0;
    repeat (3) @(negedge clk);
    impulse_ready = 1'b0;
    rst_in        = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    hist.delete();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (result_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_valid", seen, 0);
    check("wait_impulse_busy", busy, 1);
    audio_trigger = 1'b1;
    audio_in      = SW'(1234);
    @(negedge clk);
    audio_trigger = 1'b0;
    check("wait_trigger_no_drop", dropped_sample, 0);
    impulse_ready = 1'b1;
    wait_idle();
    set_delta(0, 1);
    send(-7, "after_abort");

    // Output narrowing at full scale
    set_delta(0, 32767);
    send(32767, "narrow_pos");
    set_delta(0, 32767);
    send(-32768, "narrow_neg");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
